// File: rtl/fpmax_search.sv
// Streaming argmax over a framed run of sign-magnitude fixed-point samples.
// Reports the largest sample of the frame, its zero-based position, and
// whether the frame was closed by index wrap instead of in_last_i.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; sample inputs ignored
// SCAN  | accepting samples, tracking running max and its position
// DONE  | one-cycle result pulse, then back to IDLE

module fpmax_search #(
  parameter int Q  = 15,
  parameter int N  = 32,
  parameter int IW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          in_valid_i,
  input  logic [N-1:0]  in_data_i,
  input  logic          in_last_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [N-1:0]  out_max_o,
  output logic [IW-1:0] out_index_o,
  output logic          ovf_o
);

  // Q only documents the number format; the ordering is format-agnostic.
  if (Q > N - 1) begin : g_q_range
    $error("fpmax_search: Q must not exceed the magnitude width");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   cnt_q;
  logic            first_q;
  logic [N-1:0]    run_max_q, run_max_d;
  logic [IW-1:0]   run_idx_q, run_idx_d;
  logic            busy_q;
  logic            done_q;
  logic [N-1:0]    out_max_q;
  logic [IW-1:0]   out_idx_q;
  logic            ovf_q;
  logic            take_d;
  logic            close_d;

  // Strict greater-than on sign-magnitude values; +0 ranks above -0.
  function automatic logic gt(input logic [N-1:0] a, input logic [N-1:0] b);
    logic res;
    if (a == b) begin
      res = 1'b0;
    end else if (a[N-1] != b[N-1]) begin
      res = ~a[N-1];
    end else if (!a[N-1]) begin
      res = (a[N-2:0] > b[N-2:0]);
    end else begin
      res = (a[N-2:0] < b[N-2:0]);
    end
    return res;
  endfunction

  // Candidate running max/index and frame-close decision for the current sample.
  always_comb begin
    take_d    = first_q | gt(in_data_i, run_max_q);
    run_max_d = take_d ? in_data_i : run_max_q;
    run_idx_d = take_d ? cnt_q : run_idx_q;
    close_d   = in_last_i | (cnt_q == {IW{1'b1}});
  end

  // Frame sequencing, running-max tracking and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      run_max_q <= '0;
      run_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_max_q <= '0;
      out_idx_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_SCAN;
            cnt_q   <= '0;
            first_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (in_valid_i) begin
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            first_q   <= 1'b0;
            cnt_q     <= cnt_q + 1'b1;
            if (close_d) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              out_max_q <= run_max_d;
              out_idx_q <= run_idx_d;
              ovf_q     <= ~in_last_i;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign out_max_o   = out_max_q;
  assign out_index_o = out_idx_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fpmax_search.sv
// Scoreboard bench for fpmax_search (IW=3 so index wrap is reachable).
// Stimulus pushes the hand-computed result of each frame when its closing
// sample is driven; a separate monitor pops and compares on every done pulse.

module tb_fpmax_search;

  localparam int N  = 32;
  localparam int IW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          in_valid_i;
  logic [N-1:0]  in_data_i;
  logic          in_last_i;
  logic          busy_o;
  logic          done_o;
  logic [N-1:0]  out_max_o;
  logic [IW-1:0] out_index_o;
  logic          ovf_o;

  fpmax_search #(.Q(15), .N(N), .IW(IW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .out_max_o   (out_max_o),
    .out_index_o (out_index_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0]  max;
    logic [IW-1:0] idx;
    logic          ovf;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (done_o === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("out_max", 64'(out_max_o), 64'(e.max));
          chk("out_index", 64'(out_index_o), 64'(e.idx));
          chk("ovf", 64'(ovf_o), 64'(e.ovf));
          chk("busy_at_done", 64'(busy_o), 64'd0);
        end
      end
    end
  end

  // Starts a frame; leaves the bench at the negedge where sample 0 may be driven.
  task automatic begin_frame();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
  endtask

  // Drives gap stall cycles (optionally pulsing start), then one sample.
  // When closes=1, the frame result is pushed for the monitor.
  task automatic send(input logic [N-1:0] d, input logic last, input int gap,
                      input logic closes, input logic [N-1:0] emax,
                      input logic [IW-1:0] eidx, input logic eovf);
    exp_t e;
    for (int g = 0; g < gap; g++) begin
      in_valid_i = 1'b0;
      in_data_i  = 32'hDEAD_BEEF;
      in_last_i  = 1'b1;
      start_i    = (g == 0);
      @(negedge clk_i);
    end
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    if (closes) begin
      e.max = emax; e.idx = eidx; e.ovf = eovf; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_out_max"}, 64'(out_max_o), 64'd0);
    chk({tag, "_out_index"}, 64'(out_index_o), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_zero("reset");
    rst_i = 1'b0;

    // Mixed-sign frame.
    begin_frame();
    send(32'h8000_8000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    send(32'h0000_4000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    send(32'h0000_8000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    send(32'h0000_2000, 1'b1, 0, 1'b1, 32'h0000_8000, 3'd2, 1'b0);
    idle(3);

    // Reset mid-SCAN after 3 samples clears everything, including old results.
    begin_frame();
    send(32'h0000_1000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    send(32'h0001_0000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    send(32'h0000_0001, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    rst_i = 1'b1;
    idle(2);
    check_zero("midscan_reset");
    rst_i = 1'b0;
    idle(1);

    // All-negative frame.
    begin_frame();
    send(32'h8001_0000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    send(32'h8000_4000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    send(32'h8000_8000, 1'b1, 0, 1'b1, 32'h8000_4000, 3'd1, 1'b0);
    idle(2);

    // Ties and zero signs: first +0 beats -0 and the later equal +0.
    begin_frame();
    send(32'h8000_0000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    send(32'h0000_0000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    send(32'h0000_0000, 1'b1, 0, 1'b1, 32'h0000_0000, 3'd1, 1'b0);
    idle(2);

    // Single-sample frame, next start sampled right after the DONE cycle.
    begin_frame();
    send(32'h8000_0005, 1'b1, 0, 1'b1, 32'h8000_0005, 3'd0, 1'b0);

    // Mixed-sign frame again with stalls and start pulsed inside SCAN.
    begin_frame();
    send(32'h8000_8000, 1'b0, 2, 1'b0, '0, '0, 1'b0);
    send(32'h0000_4000, 1'b0, 1, 1'b0, '0, '0, 1'b0);
    send(32'h0000_8000, 1'b0, 3, 1'b0, '0, '0, 1'b0);
    send(32'h0000_2000, 1'b1, 2, 1'b1, 32'h0000_8000, 3'd2, 1'b0);
    idle(2);

    // Overflow: 8 ascending samples without in_last close the frame by wrap.
    begin_frame();
    for (int i = 0; i < 8; i++)
      send(32'(i), 1'b0, 0, (i == 7), 32'd7, 3'd7, 1'b1);

    // Samples offered while not scanning are ignored; results hold.
    in_valid_i = 1'b1; in_last_i = 1'b1; in_data_i = 32'h7FFF_FFFF;
    idle(4);
    in_valid_i = 1'b0; in_last_i = 1'b0;
    idle(2);
    chk("hold_busy", 64'(busy_o), 64'd0);
    chk("hold_out_max", 64'(out_max_o), 64'd7);
    chk("hold_out_index", 64'(out_index_o), 64'd7);
    chk("hold_ovf", 64'(ovf_o), 64'd1);

    idle(5);
    chk("pending_results", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpmax_search.md
# fpmax_search

Streaming argmax unit for sign-magnitude fixed-point samples in the same Q-format as the rest of the datapath (bit N-1 = sign, bits N-2:0 = magnitude, Q fractional bits). It accepts a framed run of samples, one per cycle when valid, and reports the largest value and its position within the frame. It performs the greater-than ordering that is the mirror of the existing fixed-point less-than comparison. Pitch and peak-picking stages of the encoder use it wherever a per-frame maximum is needed.

## Interface
- Q, 15, fractional bits. Carried for format consistency; the compare logic does not use it.
- N, 32, sample width in bits, sign-magnitude.
- IW, 8, index width. Maximum frame length is 2^IW samples.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begins a new frame. Sampled only in IDLE.
- in_valid  in  1  in_data is presented this cycle.
- in_data  in  N  sample, sign-magnitude.
- in_last  in  1  qualifies the final sample of the frame. Meaningful only with in_valid.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse; out_max, out_index and ovf are valid from this cycle.
- out_max  out  N  largest sample of the last completed frame.
- out_index  out  IW  zero-based position of out_max within the frame.
- ovf  out  1  last frame was terminated by index wrap, not by in_last.

## Operation
- **States:** IDLE, SCAN, DONE.
- **IDLE:**
  - start=1 → SCAN. Sample counter cleared to 0 and a first-sample flag set.
  - in_valid, in_last and in_data are ignored.
- **SCAN:** each cycle with in_valid=1 accepts one sample at the rising edge.
  - First sample: loads the running max unconditionally, index=0.
  - Later samples replace the running max and index only if the sample is strictly greater than the running max.
  - Ties keep the earliest position.
  - The counter increments on every accepted sample.
  - in_valid=0 cycles stall; no state change.
  - start is ignored in SCAN.
- **Greater-than rule:** a > b exactly when the team's less-than(b, a) is true:
  - Bitwise-equal values are not greater.
  - With differing signs, the positive value is greater, so +0 (0x00000000) > -0 (0x80000000).
  - Both positive: the larger magnitude is greater.
  - Both negative: the smaller magnitude is greater.
- **End of frame:**
  - An accepted sample with in_last=1 → DONE, ovf=0.
  - An accepted sample at counter = 2^IW-1 with in_last=0 → DONE, ovf=1. The frame is forced closed.
- **DONE:** lasts one cycle with done=1, then → IDLE unconditionally. start in DONE is ignored.
- **Outputs:** out_max, out_index and ovf are updated on the edge entering DONE. They hold until the next frame's DONE entry; they are not cleared by start.
- **rst=1** at any edge, including mid-SCAN: state IDLE, counter 0, and all outputs zero. The partial frame is discarded.

## Timing
- **Reset values:** busy=0, done=0, out_max=0, out_index=0, ovf=0.
- **Start latency:** start sampled in IDLE at edge k → busy=1 from cycle k+1. The first sample can be accepted at edge k+1.
- **Throughput:** one sample per cycle, no back-pressure. There is no in_ready; upstream must not drive in_valid while busy=0.
- **Result latency:** last sample accepted at edge m → done=1 and results valid in cycle m+1, busy=0 in that same cycle. IDLE from cycle m+2, so the next start can be sampled at edge m+2.
- **Single-sample frame:** start, then in_valid with in_last on the first sample → out_index=0, done one cycle later.
- **Timing path:** the compare is combinational in one cycle; there is no internal pipelining.

## Test plan
- **Reset:** drive rst for 2 cycles mid-SCAN after 3 samples → busy=0, done never pulses, all outputs 0. A following frame works normally.
- **Mixed-sign frame:** 0x80008000 (-1.0), 0x00004000 (+0.5), 0x00008000 (+1.0), 0x00002000 (+0.25, in_last) → out_max=0x00008000, out_index=2, ovf=0. done exactly 1 cycle after the last sample.
- **All-negative frame:** 0x80010000 (-2.0), 0x80004000 (-0.5), 0x80008000 (-1.0, last) → out_max=0x80004000, out_index=1.
- **Ties and zero signs:** 0x80000000, 0x00000000, 0x00000000 (last) → out_max=0x00000000, out_index=1 (first +0 wins over the later equal +0 and over -0).
- **Stalls and ignored start:** in_valid gaps of 1–3 cycles and start pulsed during SCAN → identical result to the gap-free frame; counter unaffected.
- **Overflow, IW=3:** 8 samples 0..7 (+ascending, no in_last) → done after the 8th sample, ovf=1, out_index=7, out_max=7. Extra in_valid afterwards in IDLE is ignored.
